alu_command_sequencer: RTL

//   Command-side driver for the 16-bit accumulator ALU (breadboard).
//   - Buffers {opcode, operand} commands from a valid/ready stream in a small FIFO.
//   - Issues one command at a time on the ALU's OpCode/InputA pins.
//   - Captures the ALU's accumulator Result and Error flags and returns them on a valid/ready response stream.
//   - Sits between a host/test controller and the breadboard; it is the initiator for the ALU's responder interface.

---
 rtl/alu_command_sequencer.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/alu_command_sequencer.sv
// rtl/alu_command_sequencer.sv - command FIFO and issue/capture sequencer for the accumulator ALU
`timescale 1ns/1ps
module alu_command_sequencer #(
    parameter int DEPTH         = 4,
    parameter bit HALT_ON_ERROR = 1'b1,
    localparam int AW           = $clog2(DEPTH),
    localparam int CW           = $clog2(DEPTH) + 1
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          CmdValid,
    output logic          CmdReady,
    input  logic [3:0]    CmdOpCode,
    input  logic [15:0]   CmdOperand,
    output logic          RspValid,
    input  logic          RspReady,
    output logic [3:0]    RspOpCode,
    output logic [31:0]   RspResult,
    output logic [1:0]    RspError,
    output logic          Halted,
    input  logic          ClearHalt,
    output logic [CW-1:0] Count,
    output logic [3:0]    AluOpCode,
    output logic [15:0]   AluInputA,
    input  logic [31:0]   AluResult,
    input  logic [1:0]    AluError
);

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_UNSUP = 4'h3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_CAPTURE,
        S_RESP,
        S_HALT
    } state_t;

    state_t        r_state;
    logic [19:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [3:0]    r_cmd_op;
    logic [3:0]    r_alu_op;
    logic [15:0]   r_alu_a;
    logic [3:0]    r_rsp_op;
    logic [31:0]   r_rsp_result;
    logic [1:0]    r_rsp_error;
    logic          r_rsp_valid;
    logic          r_halted;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic [3:0]    w_head_op;
    logic [15:0]   w_head_operand;

    // Ready depends only on occupancy, so a same-cycle pop never lets a push into a full FIFO.
    assign w_full         = (r_count == CW'(DEPTH));
    assign w_empty        = (r_count == '0);
    assign w_push         = CmdValid && !w_full;
    assign w_pop          = (r_state == S_IDLE) && !w_empty;
    assign w_head_op      = r_mem[r_rd_ptr][19:16];
    assign w_head_operand = r_mem[r_rd_ptr][15:0];

    always_ff @(posedge Clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {CmdOpCode, CmdOperand};
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state      <= S_IDLE;
            r_cmd_op     <= OP_NOP;
            r_alu_op     <= OP_NOP;
            r_alu_a      <= '0;
            r_rsp_op     <= OP_NOP;
            r_rsp_result <= '0;
            r_rsp_error  <= 2'b00;
            r_rsp_valid  <= 1'b0;
            r_halted     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!w_empty) begin
                        r_cmd_op <= w_head_op;
                        // The unsupported opcode is swallowed here so the accumulator never sees it.
                        r_alu_op <= (w_head_op == OP_UNSUP) ? OP_NOP : w_head_op;
                        r_alu_a  <= w_head_operand;
                        r_state  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_rsp_error <= (r_cmd_op == OP_UNSUP) ? 2'b11 : AluError;
                    r_rsp_op    <= r_cmd_op;
                    r_alu_op    <= OP_NOP;
                    r_state     <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    r_rsp_result <= AluResult;
                    r_rsp_valid  <= 1'b1;
                    r_state      <= S_RESP;
                end
                S_RESP: begin
                    if (RspReady) begin
                        r_rsp_valid <= 1'b0;
                        if (HALT_ON_ERROR && (r_rsp_error != 2'b00)) begin
                            r_halted <= 1'b1;
                            r_state  <= S_HALT;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_HALT: begin
                    if (ClearHalt) begin
                        r_halted <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end
                default: begin
                    r_alu_op <= OP_NOP;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

    assign CmdReady  = !w_full;
    assign Count     = r_count;
    assign AluOpCode = r_alu_op;
    assign AluInputA = r_alu_a;
    assign RspValid  = r_rsp_valid;
    assign RspOpCode = r_rsp_op;
    assign RspResult = r_rsp_result;
    assign RspError  = r_rsp_error;
    assign Halted    = r_halted;

endmodule
